// File: rtl/vec_rf_pkg.sv
// Shared types, default sizes and the byte-merge helper for the multi-port vector register file.
package vec_rf_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2
    } vrf_state_t;

    localparam int VRF_DATA_W = 64;
    localparam int VRF_NREGS  = 32;

    // byte_merge works at a fixed maximum width; callers size-cast in and out,
    // so any DATA_W up to VRF_MAX_W shares the same helper.
    localparam int VRF_MAX_W  = 1024;
    localparam int VRF_MAX_BE = VRF_MAX_W / 8;

    function automatic logic [VRF_MAX_W-1:0] byte_merge(
        input logic [VRF_MAX_W-1:0]  old_v,
        input logic [VRF_MAX_W-1:0]  new_v,
        input logic [VRF_MAX_BE-1:0] be
    );
        logic [VRF_MAX_W-1:0] res;
        res = old_v;
        for (int i = 0; i < VRF_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vec_rf_rdport.sv
// One registered read port: samples the stored word, optionally forwards a same-cycle write.
// Build option: VRF_BYPASS_EN adds same-address write forwarding.
module vec_rf_rdport
    import vec_rf_pkg::*;
#(
    parameter int DATA_W = VRF_DATA_W,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] stored_data,
`ifdef VRF_BYPASS_EN
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] read_word;

    always_comb begin
        read_word = stored_data;
`ifdef VRF_BYPASS_EN
        if (wr_en && (wr_addr == req_addr)) begin
            read_word = DATA_W'(byte_merge(VRF_MAX_W'(stored_data),
                                           VRF_MAX_W'(wr_data),
                                           VRF_MAX_BE'(wr_be)));
        end
`endif
        // Without a request the output holds its last value.
        data_d  = req_en ? read_word : data_q;
        valid_d = req_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;

endmodule

// File: rtl/vec_regfile_mp.sv
// Two-read / one-byte-masked-write vector register file with zero-initialisation after reset.
// Build option: VRF_BYPASS_EN forwards same-cycle writes to reads of the same address.
module vec_regfile_mp
    import vec_rf_pkg::*;
#(
    parameter int DATA_W = VRF_DATA_W,
    parameter int NREGS  = VRF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                busy,
    input  logic                rd_en_a,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic                rd_valid_a,
    input  logic                rd_en_b,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                rd_valid_b,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [DATA_W-1:0]   wr_data
);

    localparam int BE_W = DATA_W / 8;

    vrf_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              ready;
    logic              usr_wr_en;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_wbe;
    logic [DATA_W-1:0] mem_merged;
    logic [DATA_W-1:0] mem_q [NREGS];

    assign ready     = (state_q == READY);
    assign busy      = ~ready;
    assign usr_wr_en = wr_en & ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
        case (state_q)
            RESET: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
            CLEAR: begin
                // The clear sweep borrows the write port, one register per cycle.
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                mem_wbe   = '1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(NREGS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                mem_we = wr_en;
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign mem_merged = DATA_W'(byte_merge(VRF_MAX_W'(mem_q[mem_waddr]),
                                           VRF_MAX_W'(mem_wdata),
                                           VRF_MAX_BE'(mem_wbe)));

    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_merged;
        end
    end

    logic              port_en    [2];
    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_data  [2];
    logic              port_valid [2];

    assign port_en[0]   = rd_en_a & ready;
    assign port_en[1]   = rd_en_b & ready;
    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rdport
        vec_rf_rdport #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rdport (
            .clk         (clk),
            .rst         (rst),
            .req_en      (port_en[gi]),
            .req_addr    (port_addr[gi]),
            .stored_data (mem_q[port_addr[gi]]),
`ifdef VRF_BYPASS_EN
            .wr_en       (usr_wr_en),
            .wr_addr     (wr_addr),
            .wr_be       (wr_be),
            .wr_data     (wr_data),
`endif
            .rd_data     (port_data[gi]),
            .rd_valid    (port_valid[gi])
        );
    end

    assign rd_data_a  = port_data[0];
    assign rd_valid_a = port_valid[0];
    assign rd_data_b  = port_data[1];
    assign rd_valid_b = port_valid[1];

    logic unused_ok;
    assign unused_ok = usr_wr_en;

endmodule

// File: tb/tb_vec_regfile_mp.sv
// Directed bench for vec_regfile_mp: init timing, dual reads, byte masks, hazard, busy drops.
module tb_vec_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    logic        rd_en_a, rd_en_b;
    logic [4:0]  rd_addr_a, rd_addr_b;
    logic [63:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_be;
    logic [63:0] wr_data;

    int checks = 0;
    int errors = 0;
    int busy_cnt;
    logic [63:0] hazard_exp;

    always #5 clk = ~clk;

    vec_regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .busy       (busy),
        .rd_en_a    (rd_en_a),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_valid_a (rd_valid_a),
        .rd_en_b    (rd_en_b),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .rd_valid_b (rd_valid_b),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_be      (wr_be),
        .wr_data    (wr_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic idle();
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0;
    endtask

    // Count busy cycles after rst is released at a falling edge, bounded.
    task automatic count_busy(output int n);
        n = 0;
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 5'(i);
            rd_en_b = 1'b1; rd_addr_b = 5'(31 - i);
            @(negedge clk);
            check({tag, "_a"}, rd_data_a, 64'h0);
            check({tag, "_b"}, rd_data_b, 64'h0);
            check({tag, "_va"}, {63'h0, rd_valid_a & rd_valid_b}, 64'h1);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1; idle();
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'h0, busy}, 64'h1);
        check("rst_valid_a", {63'h0, rd_valid_a}, 64'h0);
        check("rst_data_a", rd_data_a, 64'h0);
        check("rst_data_b", rd_data_b, 64'h0);

        count_busy(busy_cnt);
        check("init_busy_cycles", 64'(busy_cnt), 64'd32);
        read_all_zero("init_rd");

        // Dirty a high register, then abort the clear at cycle 10 and restart it.
        write(5'd20, 64'hDEAD_BEEF_0000_0001, 8'hFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        @(negedge clk);
        count_busy(busy_cnt);
        check("mid_busy_cycles", 64'(busy_cnt), 64'd32);
        read_all_zero("mid_rd");

        write(5'd5, 64'hABCDEF0123456789, 8'hFF);
        rd_en_a = 1'b1; rd_addr_a = 5'd5;
        rd_en_b = 1'b1; rd_addr_b = 5'd5;
        @(negedge clk);
        idle();
        check("full_a", rd_data_a, 64'hABCDEF0123456789);
        check("full_b", rd_data_b, 64'hABCDEF0123456789);
        check("full_valid", {62'h0, rd_valid_a, rd_valid_b}, 64'h3);
        @(negedge clk);
        check("hold_valid_a", {63'h0, rd_valid_a}, 64'h0);
        check("hold_data_a", rd_data_a, 64'hABCDEF0123456789);

        write(5'd5, 64'h1111111111111111, 8'h0F);
        rd_en_a = 1'b1; rd_addr_a = 5'd5;
        @(negedge clk);
        idle();
        check("mask_r5", rd_data_a, 64'hABCDEF0111111111);

        write(5'd5, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        rd_en_b = 1'b1; rd_addr_b = 5'd5;
        @(negedge clk);
        idle();
        check("be0_r5", rd_data_b, 64'hABCDEF0111111111);

`ifdef VRF_BYPASS_EN
        hazard_exp = 64'hFFFF;
`else
        hazard_exp = 64'h0;
`endif
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hFFFF; wr_be = 8'h03;
        rd_en_a = 1'b1; rd_addr_a = 5'd7;
        @(negedge clk);
        idle();
        check("hazard_r7", rd_data_a, hazard_exp);
        rd_en_a = 1'b1; rd_addr_a = 5'd7;
        @(negedge clk);
        idle();
        check("after_hazard_r7", rd_data_a, 64'hFFFF);

        // Requests late in the clear, after r3 has already been zeroed.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; wr_be = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
        rd_en_b = 1'b1; rd_addr_b = 5'd3;
        @(negedge clk);
        idle();
        check("busy_no_valid", {62'h0, rd_valid_a, rd_valid_b}, 64'h0);
        busy_cnt = 0;
        while (busy && busy_cnt < 60) begin
            @(negedge clk);
            busy_cnt++;
        end
        check("busy_released", {63'h0, busy}, 64'h0);
        rd_en_a = 1'b1; rd_addr_a = 5'd3;
        @(negedge clk);
        idle();
        check("busy_r3", rd_data_a, 64'h0);
        check("busy_r3_valid", {63'h0, rd_valid_a}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_regfile_mp.md
# vec_regfile_mp

Parametrised multi-port vector register file, successor to the single-port `vec_regfile`. It provides two independent registered read ports and one byte-masked write port, so the vector datapath can fetch two source operands and retire one result per cycle. After reset, an internal state machine zero-initialises every register before the file accepts traffic.

## Interface
Parameters:
- `DATA_W`, 64: register width in bits; multiple of 8.
- `NREGS`, 32: number of registers; power of two, at least 2.
- `ADDR_W`, `$clog2(NREGS)`: address width; derived, not overridden.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `busy` out 1: initialisation in progress; all requests are ignored while high.
- `rd_en_a` in 1: read request, port A.
- `rd_addr_a` in ADDR_W: read address, port A.
- `rd_data_a` out DATA_W: read data, port A.
- `rd_valid_a` out 1: `rd_data_a` is valid this cycle.
- `rd_en_b`, `rd_addr_b`, `rd_data_b`, `rd_valid_b`: port B, identical to port A.
- `wr_en` in 1: write request.
- `wr_addr` in ADDR_W: write address.
- `wr_be` in DATA_W/8: byte enables; bit i enables byte i, `data[8i+7:8i]`.
- `wr_data` in DATA_W: write data.

## Operation
- FSM states are `RESET`, `CLEAR` and `READY`.
  - `rst` high forces `RESET`. While in `RESET`: `busy`=1, clear counter=0, `rd_data_*`=0, `rd_valid_*`=0.
  - The first cycle with `rst` low moves `RESET` to `CLEAR`.
  - In `CLEAR`, each cycle writes zero to the register at the counter value, then increments the counter.
  - After register NREGS-1 is written, the FSM moves to `READY` and drops `busy`.
- Asserting `rst` during `CLEAR` returns the FSM to `RESET`. The clear restarts from register 0.
- Write (in `READY` only): at the clock edge, byte i of register `wr_addr` takes byte i of `wr_data` when `wr_be[i]`=1. All other bytes keep their value. `wr_en` with `wr_be`=0 changes nothing.
- Read (in `READY` only): `rd_en_x` samples `rd_addr_x`. Data and `rd_valid_x`=1 appear on the next cycle.
  - If `rd_en_x` was low in the previous cycle, `rd_valid_x`=0 and `rd_data_x` holds its last value.
- Both ports may read the same address in the same cycle. Each port returns the same data.
- Requests made while `busy`=1 are dropped silently: no write occurs and no `rd_valid` follows.
- Read-during-write to the same address in the same cycle: behaviour is set by `VRF_BYPASS_EN` (see Configuration).

## Timing
- Read latency is 1 cycle. A new read can be issued on every port every cycle.
- A write becomes visible to a read issued on the next cycle. Same-cycle visibility depends on `VRF_BYPASS_EN`.
- Initialisation lasts NREGS cycles after the `rst` falling edge. With NREGS=32, `busy` is low from cycle 32 onward, counting the first cycle with `rst` low as cycle 0.
- There is no combinational path from any input to any output.

## Configuration
- `VRF_BYPASS_EN` defined: when a read and a write hit the same address in the same cycle, the read returns the merged value. Bytes with `wr_be`=1 come from `wr_data`; the other bytes come from the stored value.
- `VRF_BYPASS_EN` undefined: in the same case, the read returns the pre-write value. There is no forwarding logic.

## Structure
- Package `vec_rf_pkg` holds:
  - the FSM state enum `vrf_state_t` (`RESET`, `CLEAR`, `READY`);
  - the default constants `VRF_DATA_W`=64 and `VRF_NREGS`=32;
  - the function `byte_merge(old, new, be)`, shared by the write path and the bypass.
- One sub-module, `vec_rf_rdport`, instantiated twice. It contains the address sampling, the optional bypass mux, and the output/valid registers.

## Test plan
- Reset then init: hold `rst` 3 cycles, then release. Check `busy`=1 for exactly 32 cycles. Then read every address and check all reads return 64'h0.
- Reset mid-init: assert `rst` at cycle 10 of `CLEAR`, then release. Check `busy` stays high for a full 32 further cycles, and all registers read 0.
- Full write, dual read: write 64'hABCDEF0123456789 to r5 with `wr_be`=8'hFF. Next cycle, read A=r5 and B=r5. One cycle later, check both outputs equal 64'hABCDEF0123456789 with both valids high.
- Byte mask: r5 holds 64'hABCDEF0123456789. Write 64'h1111111111111111 with `wr_be`=8'h0F. A read of r5 must return 64'hABCDEF0111111111.
- Same-cycle hazard: r7 holds 0. Write 64'hFFFF to r7 with `wr_be`=8'h03 while reading r7 on port A in the same cycle. Check the read returns 64'hFFFF with `VRF_BYPASS_EN` defined, and 64'h0 without it.
- Requests during busy: issue a write to r3 (64'h55) and a read during `CLEAR`. Check no `rd_valid` follows, and that r3 reads 0 after `busy` falls.
